// File: rtl/tlul_spi_master_v2.sv
// TL-UL SPI master: CTRL/DIV/DATA/STATUS registers, TX/RX FIFOs, four SPI modes,
// 8/16/32-bit words, MSB/LSB-first ordering and manual chip-select hold.
// state | meaning
// IDLE  | waiting for en and TX data; CS may still be held low
// LEAD  | CS setup, one half-period
// SHIFT | 2*len SCLK edges
// TRAIL | CS hold, one half-period
// CSHI  | minimum CS-high time, one half-period
module tlul_spi_master_v2 #(
  parameter int TL_RS      = 4,
  parameter int TL_SZ      = 4,
  parameter int CS         = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             spi_clock_i,
  input  logic             spi_reset_i,
  input  logic [2:0]       spi_a_opcode,
  input  logic [2:0]       spi_a_param,
  input  logic [TL_SZ-1:0] spi_a_size,
  input  logic [TL_RS-1:0] spi_a_source,
  input  logic [3:0]       spi_a_address,
  input  logic [3:0]       spi_a_mask,
  input  logic [31:0]      spi_a_data,
  input  logic             spi_a_corrupt,
  input  logic             spi_a_valid,
  output logic             spi_a_ready,
  output logic [2:0]       spi_d_opcode,
  output logic [1:0]       spi_d_param,
  output logic [TL_SZ-1:0] spi_d_size,
  output logic [TL_RS-1:0] spi_d_source,
  output logic             spi_d_denied,
  output logic [31:0]      spi_d_data,
  output logic             spi_d_corrupt,
  output logic             spi_d_valid,
  input  logic             spi_d_ready,
  output logic             spi_sclk_o,
  output logic             spi_mosi_o,
  input  logic             spi_miso_i,
  output logic [CS-1:0]    spi_cs_n_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, CSHI} state_t;
  state_t state, state_nxt;

  logic [31:0] ctrl, tx_word, rx_word, rx_in, rdata, wmask, status, tx_head;
  logic [15:0] div, div_l, cnt;
  logic [31:0] tx_mem [FIFO_DEPTH];
  logic [31:0] rx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wp, tx_rp, rx_wp, rx_rp, tx_cnt, rx_cnt;
  logic        tx_full, tx_empty, rx_full, rx_empty, tx_ovf, rx_ovf;
  logic        cpha_l, lsb_l;
  logic [5:0]  len_l, len_new, ecnt;
  logic [4:0]  idx, idx_nxt, pos, pos_nxt, pos0;
  logic [1:0]  sel;
  logic        acc, is_put, is_get, wr, rd, w1c, tl_push, tl_pop, push_ok;
  logic        tick, last_edge, load, rx_push, rx_ok, cs_on, cs_off, busy, cs_low;
  logic [CS-1:0] cs_vec;
  logic        unused;

  assign unused = ^{spi_a_param, spi_a_corrupt, spi_a_address[1:0],
                    ctrl[31:17], ctrl[15:12], ctrl[7:6]};

  assign tx_cnt   = tx_wp - tx_rp;
  assign rx_cnt   = rx_wp - rx_rp;
  assign tx_empty = tx_wp == tx_rp;
  assign rx_empty = rx_wp == rx_rp;
  assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
  assign rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
  assign busy     = state != IDLE;
  assign cs_low   = ~&spi_cs_n_o;
  assign status   = {8'h0, 8'(rx_cnt), 8'(tx_cnt), 1'b0, rx_ovf, tx_ovf,
                     rx_empty, rx_full, tx_empty, tx_full, busy};

  assign spi_a_ready = ~spi_d_valid | spi_d_ready;
  assign acc     = spi_a_valid & spi_a_ready;
  assign is_put  = (spi_a_opcode == 3'd0) || (spi_a_opcode == 3'd1);
  assign is_get  = spi_a_opcode == 3'd4;
  assign sel     = spi_a_address[3:2];
  assign wr      = acc & is_put;
  assign rd      = acc & is_get;
  assign w1c     = wr && (sel == 2'd3) && spi_a_mask[0];
  assign wmask   = {{8{spi_a_mask[3]}}, {8{spi_a_mask[2]}}, {8{spi_a_mask[1]}}, {8{spi_a_mask[0]}}};
  assign tl_push = wr && (sel == 2'd2);
  assign tl_pop  = rd && (sel == 2'd2) && !rx_empty;
  assign push_ok = tl_push && !tx_full;
  // A full RX that is being read this cycle still has room for the FSM's word.
  assign rx_ok   = rx_push && (!rx_full || tl_pop);

  always_comb begin
    rdata = 32'h0;
    case (sel)
      2'd0:    rdata = ctrl;
      2'd1:    rdata = {16'h0, div};
      2'd2:    rdata = rx_empty ? 32'h0 : rx_mem[rx_rp[AW-1:0]];
      default: rdata = status;
    endcase
  end

  always_ff @(posedge spi_clock_i) begin
    if (!spi_reset_i) begin
      spi_d_valid  <= 1'b0;
      spi_d_opcode <= 3'd0;
      spi_d_size   <= '0;
      spi_d_source <= '0;
      spi_d_denied <= 1'b0;
      spi_d_data   <= 32'h0;
    end else if (acc) begin
      spi_d_valid  <= 1'b1;
      spi_d_opcode <= is_get ? 3'd1 : 3'd0;
      spi_d_size   <= spi_a_size;
      spi_d_source <= spi_a_source;
      spi_d_denied <= !(is_put || is_get);
      spi_d_data   <= is_get ? rdata : 32'h0;
    end else if (spi_d_ready) begin
      spi_d_valid  <= 1'b0;
    end
  end

  assign spi_d_param   = 2'b00;
  assign spi_d_corrupt = 1'b0;

  always_ff @(posedge spi_clock_i) begin
    if (!spi_reset_i) begin
      ctrl   <= 32'h0;
      div    <= 16'h0;
      tx_wp  <= '0;
      tx_rp  <= '0;
      rx_wp  <= '0;
      rx_rp  <= '0;
      tx_ovf <= 1'b0;
      rx_ovf <= 1'b0;
    end else begin
      if (wr && sel == 2'd0) ctrl <= ((ctrl & ~wmask) | (spi_a_data & wmask)) & 32'h0001_0F3F;
      if (wr && sel == 2'd1) div <= (div & ~wmask[15:0]) | (spi_a_data[15:0] & wmask[15:0]);
      if (push_ok) tx_wp <= tx_wp + PTR_ONE;
      if (load)    tx_rp <= tx_rp + PTR_ONE;
      if (rx_ok)   rx_wp <= rx_wp + PTR_ONE;
      if (tl_pop)  rx_rp <= rx_rp + PTR_ONE;
      tx_ovf <= (tx_ovf & ~(w1c & spi_a_data[5])) | (tl_push & tx_full);
      rx_ovf <= (rx_ovf & ~(w1c & spi_a_data[6])) | (rx_push & ~rx_ok);
    end
  end

  always_ff @(posedge spi_clock_i) begin
    if (push_ok) tx_mem[tx_wp[AW-1:0]] <= spi_a_data & wmask;
    if (rx_ok)   rx_mem[rx_wp[AW-1:0]] <= rx_in;
  end

  always_comb begin
    cs_vec = '0;
    for (int i = 0; i < CS; i++) cs_vec[i] = (ctrl[11:8] == 4'(i));
  end

  always_comb begin
    case (ctrl[5:4])
      2'd0:    len_new = 6'd8;
      2'd1:    len_new = 6'd16;
      default: len_new = 6'd32;
    endcase
  end

  assign tx_head   = tx_mem[tx_rp[AW-1:0]];
  assign pos0      = ctrl[3] ? 5'd0 : 5'(len_new - 6'd1);
  assign idx_nxt   = idx + 5'd1;
  assign pos       = lsb_l ? idx : 5'(len_l - 6'd1 - {1'b0, idx});
  assign pos_nxt   = lsb_l ? idx_nxt : 5'(len_l - 6'd1 - {1'b0, idx_nxt});
  assign tick      = busy && (cnt == 16'd0);
  assign last_edge = {1'b0, ecnt} == ({len_l, 1'b0} - 7'd1);
  // With cpha=1 the final sample lands on the last edge, so fold it in directly.
  assign rx_in     = cpha_l ? (rx_word | (32'(spi_miso_i) << pos)) : rx_word;

  always_ff @(posedge spi_clock_i) begin
    if (!spi_reset_i) state <= IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    rx_push   = 1'b0;
    cs_on     = 1'b0;
    cs_off    = 1'b0;
    case (state)
      IDLE: begin
        if (ctrl[0] && !tx_empty) begin
          load = 1'b1; cs_on = 1'b1; state_nxt = LEAD;
        end else if (cs_low && !ctrl[16]) begin
          cs_off = 1'b1; state_nxt = CSHI;
        end
      end
      LEAD:  if (tick) state_nxt = SHIFT;
      SHIFT: if (tick && last_edge) begin rx_push = 1'b1; state_nxt = TRAIL; end
      TRAIL: begin
        if (tick) begin
          if (ctrl[16] && ctrl[0] && !tx_empty) begin
            load = 1'b1; cs_on = 1'b1; state_nxt = LEAD;
          end else if (ctrl[16]) begin
            state_nxt = IDLE;
          end else begin
            cs_off = 1'b1; state_nxt = CSHI;
          end
        end
      end
      CSHI:    if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge spi_clock_i) begin
    if (!spi_reset_i) begin
      spi_sclk_o <= 1'b0;
      spi_mosi_o <= 1'b0;
      spi_cs_n_o <= '1;
      cnt        <= 16'h0;
      div_l      <= 16'h0;
      tx_word    <= 32'h0;
      rx_word    <= 32'h0;
      cpha_l     <= 1'b0;
      lsb_l      <= 1'b0;
      len_l      <= 6'd8;
      ecnt       <= 6'd0;
      idx        <= 5'd0;
    end else begin
      if (state_nxt != state || tick) cnt <= load ? div : div_l;
      else if (busy)                  cnt <= cnt - 16'd1;
      if (cs_on)       spi_cs_n_o <= ~cs_vec;
      else if (cs_off) spi_cs_n_o <= '1;
      if (load) begin
        tx_word    <= tx_head;
        rx_word    <= 32'h0;
        div_l      <= div;
        cpha_l     <= ctrl[2];
        lsb_l      <= ctrl[3];
        len_l      <= len_new;
        ecnt       <= 6'd0;
        idx        <= 5'd0;
        spi_sclk_o <= ctrl[1];
        spi_mosi_o <= tx_head[pos0];
      end else if (state == IDLE) begin
        spi_sclk_o <= ctrl[1];
      end else if (state == SHIFT && tick) begin
        spi_sclk_o <= ~spi_sclk_o;
        ecnt       <= ecnt + 6'd1;
        if (!ecnt[0]) begin
          if (cpha_l) spi_mosi_o <= tx_word[pos];
          else        rx_word[pos] <= spi_miso_i;
        end else begin
          idx <= idx_nxt;
          if (cpha_l) rx_word[pos] <= spi_miso_i;
          else        spi_mosi_o <= tx_word[pos_nxt];
        end
      end
    end
  end
endmodule

// File: tb/tb_tlul_spi_master_v2.sv
// Directed + randomized bench for tlul_spi_master_v2 with MISO looped back to MOSI.
module tb_tlul_spi_master_v2;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  a_opcode, a_param;
  logic [3:0]  a_size, a_source, a_address, a_mask;
  logic [31:0] a_data;
  logic        a_corrupt, a_valid, a_ready;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [3:0]  d_size, d_source;
  logic        d_denied, d_corrupt, d_valid, d_ready;
  logic [31:0] d_data;
  logic        sclk, mosi, miso;
  logic [1:0]  cs_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign miso = mosi;

  tlul_spi_master_v2 dut (
    .spi_clock_i(clk), .spi_reset_i(rst_n),
    .spi_a_opcode(a_opcode), .spi_a_param(a_param), .spi_a_size(a_size),
    .spi_a_source(a_source), .spi_a_address(a_address), .spi_a_mask(a_mask),
    .spi_a_data(a_data), .spi_a_corrupt(a_corrupt), .spi_a_valid(a_valid),
    .spi_a_ready(a_ready), .spi_d_opcode(d_opcode), .spi_d_param(d_param),
    .spi_d_size(d_size), .spi_d_source(d_source), .spi_d_denied(d_denied),
    .spi_d_data(d_data), .spi_d_corrupt(d_corrupt), .spi_d_valid(d_valid),
    .spi_d_ready(d_ready), .spi_sclk_o(sclk), .spi_mosi_o(mosi),
    .spi_miso_i(miso), .spi_cs_n_o(cs_n)
  );

  // Bus monitor: records every SCLK toggle (cycle, MOSI) and CS[0] rising edges.
  int   cyc = 0;
  int   tog_t[$];
  logic tog_mosi[$];
  logic [1:0] cs_first;
  int   cs_rise = 0;
  logic prev_sclk = 1'b0;
  logic [1:0] prev_cs = 2'b11;
  always @(posedge clk) begin
    #2;
    cyc++;
    if (rst_n === 1'b1) begin
      if (sclk !== prev_sclk) begin
        tog_t.push_back(cyc);
        tog_mosi.push_back(mosi);
        if (tog_t.size() == 1) cs_first = cs_n;
      end
      if (prev_cs[0] === 1'b0 && cs_n[0] === 1'b1) cs_rise++;
    end
    prev_sclk = sclk;
    prev_cs   = cs_n;
  end

  initial begin
    #500000;
    $display("FAIL watchdog no finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tl_xact(input logic [2:0] op, input logic [3:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic den);
    int n;
    logic [3:0] src;
    src = 4'($urandom_range(0, 15));
    n = 0;
    @(negedge clk);
    a_opcode = op; a_address = addr; a_data = wdata; a_mask = 4'hF;
    a_source = src; a_valid = 1'b1;
    while (a_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    a_valid = 1'b0;
    checks++;
    assert (d_valid === 1'b1 && d_source === src) else begin
      errors++;
      $error("FAIL tl_resp valid=%b src=%h exp_src=%h", d_valid, d_source, src);
    end
    rdata = d_data;
    den   = d_denied;
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] wdata);
    logic [31:0] r; logic den;
    tl_xact(3'd0, addr, wdata, r, den);
  endtask

  task automatic rd(input logic [3:0] addr, output logic [31:0] rdata);
    logic den;
    tl_xact(3'd4, addr, 32'h0, rdata, den);
  endtask

  task automatic wait_idle();
    logic [31:0] st;
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      rd(4'hC, st);
      if (!st[0] && st[2]) done = 1'b1;
    end
    chk("wait_idle", 32'(done), 32'd1);
  endtask

  // Reference: loopback returns the word truncated to len; MOSI at the sampling
  // edges carries the word's bits in the selected order.
  task automatic run_xfer(input logic cpol, input logic cpha, input logic lsb, input logic [1:0] len,
                          input logic [3:0] cs_sel, input logic [15:0] dv, input logic [31:0] data);
    int nb, bad;
    logic [31:0] exp_word, got, cw;
    logic [1:0] ecs;
    nb = (len == 2'd0) ? 8 : (len == 2'd1) ? 16 : 32;
    exp_word = (nb == 32) ? data : data & ((32'h1 << nb) - 32'h1);
    ecs = (cs_sel < 4'd2) ? ~(2'b01 << cs_sel) : 2'b11;
    cw = {20'h0, cs_sel, 2'b00, len, lsb, cpha, cpol, 1'b1};
    wr(4'h4, {16'h0, dv});
    wr(4'h0, cw);
    repeat (2) @(negedge clk);
    tog_t.delete();
    tog_mosi.delete();
    wr(4'h8, data);
    wait_idle();
    chk("edges", 32'(tog_t.size()), 32'(2 * nb));
    bad = 0;
    for (int i = 1; i < tog_t.size(); i++)
      if (tog_t[i] - tog_t[i-1] != int'(dv) + 1) bad++;
    chk("half_period", 32'(bad), 32'd0);
    bad = 0;
    for (int j = 0; j < nb; j++) begin
      int k;
      logic eb;
      k  = 2 * j + (cpha ? 1 : 0);
      eb = lsb ? data[j] : data[nb-1-j];
      if (k >= tog_mosi.size() || tog_mosi[k] !== eb) bad++;
    end
    chk("mosi_bits", 32'(bad), 32'd0);
    chk("cs_active", 32'(cs_first), 32'(ecs));
    chk("cs_after", 32'(cs_n), 32'h3);
    chk("sclk_idle", 32'(sclk), 32'(cpol));
    rd(4'h8, got);
    chk("rx_word", got, exp_word);
  endtask

  initial begin
    logic [31:0] st, g;
    logic        den;
    logic [31:0] hw[3];
    logic [31:0] ov[9];

    rst_n = 1'b0; a_valid = 1'b1; a_opcode = 3'd4; a_param = 3'd0; a_size = 4'd2;
    a_source = 4'd0; a_address = 4'hC; a_mask = 4'hF; a_data = 32'h0; a_corrupt = 1'b0;
    d_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_a_ready", 32'(a_ready), 32'd1);
    chk("rst_d_valid", 32'(d_valid), 32'd0);
    chk("rst_d_data", d_data, 32'h0);
    chk("rst_cs_n", 32'(cs_n), 32'h3);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    rst_n = 1'b1; a_valid = 1'b0;
    rd(4'hC, st);
    chk("rst_status", st, 32'h0000_0014);
    chk("get_opcode", 32'(d_opcode), 32'd1);

    run_xfer(1'b0, 1'b0, 1'b0, 2'd0, 4'd1, 16'd1, 32'h0000_00A5);
    run_xfer(1'b1, 1'b1, 1'b1, 2'd2, 4'd0, 16'd1, 32'h1234_5678);
    for (int r = 0; r < 6; r++)
      run_xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               2'($urandom_range(0, 3)), 4'($urandom_range(0, 2)), 16'($urandom_range(0, 2)),
               $urandom);

    // Chip-select hold across three back-to-back words.
    wr(4'h0, 32'h0);
    wr(4'h4, 32'h0);
    for (int i = 0; i < 3; i++) begin hw[i] = $urandom; wr(4'h8, hw[i]); end
    cs_rise = 0;
    wr(4'h0, 32'h0001_0001);
    wait_idle();
    chk("hold_cs_low", 32'(cs_n), 32'h2);
    chk("hold_no_rise", 32'(cs_rise), 32'd0);
    rd(4'hC, st);
    chk("hold_rx_count", 32'(st[23:16]), 32'd3);
    wr(4'h0, 32'h0000_0001);
    repeat (4) @(negedge clk);
    chk("hold_release", 32'(cs_n), 32'h3);
    chk("hold_one_rise", 32'(cs_rise), 32'd1);
    for (int i = 0; i < 3; i++) begin rd(4'h8, g); chk("hold_rx", g, hw[i] & 32'hFF); end

    // TX and RX overflow.
    wr(4'h0, 32'h0);
    for (int i = 0; i < 9; i++) begin ov[i] = 32'h100 + 32'(i) * 32'h11; wr(4'h8, ov[i]); end
    rd(4'hC, st);
    chk("tx_full", 32'(st[1]), 32'd1);
    chk("tx_ovf", 32'(st[5]), 32'd1);
    chk("tx_count", 32'(st[15:8]), 32'd8);
    wr(4'hC, 32'h20);
    rd(4'hC, st);
    chk("tx_ovf_clr", 32'(st[5]), 32'd0);
    wr(4'h0, 32'h1);
    wait_idle();
    rd(4'hC, st);
    chk("rx_full", 32'(st[3]), 32'd1);
    chk("rx_ovf_pre", 32'(st[6]), 32'd0);
    wr(4'h8, 32'hEE);
    wait_idle();
    rd(4'hC, st);
    chk("rx_ovf", 32'(st[6]), 32'd1);
    for (int i = 0; i < 8; i++) begin rd(4'h8, g); chk("rx_keep", g, ov[i] & 32'hFF); end
    rd(4'h8, g);
    chk("rx_drop_gone", g, 32'h0);
    wr(4'hC, 32'h40);
    rd(4'hC, st);
    chk("status_clean", st, 32'h0000_0014);

    // Unsupported opcode is denied with no side effect.
    tl_xact(3'd5, 4'h0, 32'hFFFF_FFFF, g, den);
    chk("deny_flag", 32'(den), 32'd1);
    chk("deny_opcode", 32'(d_opcode), 32'd0);
    rd(4'h0, g);
    chk("deny_no_effect", g, 32'h1);

    // D-channel backpressure.
    @(negedge clk);
    @(negedge clk);
    d_ready = 1'b0;
    a_opcode = 3'd4; a_address = 4'hC; a_mask = 4'hF; a_source = 4'h9; a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_a_ready", 32'(a_ready), 32'd0);
      chk("stall_d_valid", 32'(d_valid), 32'd1);
      chk("stall_d_data", d_data, 32'h0000_0014);
      chk("stall_d_source", 32'(d_source), 32'h9);
    end
    d_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release", 32'(d_valid), 32'd0);

    rd(4'h8, g);
    chk("rx_empty_read", g, 32'h0);
    rd(4'hC, st);
    chk("rx_count_zero", 32'(st[23:16]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
